// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Owns the write/clear side of the 8x8 FileRegister. Two requesters share the
// single write port under round-robin arbitration, and a clear command runs an
// 8-cycle sweep that zeroes every register through the per-address reset.
// Every output toward FileRegister is registered; grants are combinational so a
// requester sees acceptance in the same cycle it asks.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] data0,
    output logic                  gnt0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  gnt1,
    input  logic                  clear_all,
    output logic                  busy,
    output logic                  clear_done,
    output logic                  rf_load,
    output logic                  rf_reset,
    output logic [ADDR_WIDTH-1:0] rf_address,
    output logic [DATA_WIDTH-1:0] rf_d_in
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Pointer encoding: 0 favours port 0 on a tie, 1 favours port 1.
    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] cnt_r, cnt_s;
    logic                  ptr_r, ptr_s;
    logic                  rf_load_r, rf_load_s;
    logic                  rf_reset_r, rf_reset_s;
    logic [ADDR_WIDTH-1:0] rf_address_r, rf_address_s;
    logic [DATA_WIDTH-1:0] rf_d_in_r, rf_d_in_s;
    logic                  clear_done_r, clear_done_s;
    logic                  gnt0_s, gnt1_s;

    // Grant decode: a sweep (running or being requested) blocks all writes,
    // otherwise a sole requester wins and a tie goes to the pointer's port.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if ((state_r != IDLE) || clear_all) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (req0 && req1) begin
            gnt0_s = ~ptr_r;
            gnt1_s = ptr_r;
        end else begin
            gnt0_s = req0;
            gnt1_s = req1;
        end
    end

    // Next-state and next-output decode for the IDLE/CLEAR controller.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        ptr_s        = ptr_r;
        rf_load_s    = 1'b0;
        rf_reset_s   = 1'b0;
        rf_address_s = rf_address_r;
        rf_d_in_s    = rf_d_in_r;
        clear_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (clear_all) begin
                    state_s      = CLEAR;
                    cnt_s        = ADDR_ZERO;
                    rf_reset_s   = 1'b1;
                    rf_address_s = ADDR_ZERO;
                end else if (req0 && gnt0_s) begin
                    rf_load_s    = 1'b1;
                    rf_address_s = addr0;
                    rf_d_in_s    = data0;
                    ptr_s        = 1'b1;
                end else if (req1 && gnt1_s) begin
                    rf_load_s    = 1'b1;
                    rf_address_s = addr1;
                    rf_d_in_s    = data1;
                    ptr_s        = 1'b0;
                end else begin
                    rf_load_s    = 1'b0;
                end
            end
            CLEAR: begin
                if (cnt_r != LAST_ADDR) begin
                    cnt_s        = cnt_r + ADDR_ONE;
                    rf_address_s = cnt_r + ADDR_ONE;
                    rf_reset_s   = 1'b1;
                end else begin
                    state_s      = IDLE;
                    cnt_s        = ADDR_ZERO;
                    rf_reset_s   = 1'b0;
                    clear_done_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = ADDR_ZERO;
            end
        endcase
    end

    // State and output registers; reset abandons any sweep in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            cnt_r        <= ADDR_ZERO;
            ptr_r        <= 1'b0;
            rf_load_r    <= 1'b0;
            rf_reset_r   <= 1'b0;
            rf_address_r <= ADDR_ZERO;
            rf_d_in_r    <= DATA_ZERO;
            clear_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            ptr_r        <= ptr_s;
            rf_load_r    <= rf_load_s;
            rf_reset_r   <= rf_reset_s;
            rf_address_r <= rf_address_s;
            rf_d_in_r    <= rf_d_in_s;
            clear_done_r <= clear_done_s;
        end
    end

    assign gnt0       = gnt0_s;
    assign gnt1       = gnt1_s;
    assign busy       = (state_r == CLEAR);
    assign clear_done = clear_done_r;
    assign rf_load    = rf_load_r;
    assign rf_reset   = rf_reset_r;
    assign rf_address = rf_address_r;
    assign rf_d_in    = rf_d_in_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: models the downstream FileRegister, keeps a
// queue of expected writes that is drained whenever rf_load is seen.
module tb_regfile_write_arbiter;

    logic       clk;
    logic       reset;
    logic       req0, req1, gnt0, gnt1;
    logic [2:0] addr0, addr1;
    logic [7:0] data0, data1;
    logic       clear_all, busy, clear_done;
    logic       rf_load, rf_reset;
    logic [2:0] rf_address;
    logic [7:0] rf_d_in;

    typedef struct packed {
        logic [2:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        sb_q[$];
    logic [7:0] mem [8];
    int         chk_cnt  = 0;
    int         pass_cnt = 0;

    regfile_write_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
        .clear_all(clear_all), .busy(busy), .clear_done(clear_done),
        .rf_load(rf_load), .rf_reset(rf_reset),
        .rf_address(rf_address), .rf_d_in(rf_d_in)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FileRegister model: per-address reset wins, not touched by the block reset
    always @(posedge clk) begin
        if (rf_reset) mem[rf_address] <= 8'h00;
        else if (rf_load) mem[rf_address] <= rf_d_in;
    end

    // Scoreboard drain and load/reset exclusivity monitor
    always @(negedge clk) begin
        if (reset) begin
            chk_cnt++;
            if (rf_load && rf_reset) $display("FAIL load_reset_excl: both high at %0t", $time);
            else pass_cnt++;
            if (rf_load) begin
                chk_cnt++;
                if (sb_q.size() == 0) begin
                    $display("FAIL sb_unexpected: write a=%0d d=%h, expected none", rf_address, rf_d_in);
                end else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    if ({rf_address, rf_d_in} !== {e.a, e.d})
                        $display("FAIL sb_write: got a=%0d d=%h, expected a=%0d d=%h", rf_address, rf_d_in, e.a, e.d);
                    else pass_cnt++;
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({rf_load, rf_reset, rf_address, rf_d_in, clear_done, busy, gnt0, gnt1} !== 17'd0)
            $display("FAIL reset_outputs: got %h, expected 0",
                     {rf_load, rf_reset, rf_address, rf_d_in, clear_done, busy, gnt0, gnt1});
        else pass_cnt++;
        clear_all = 1'b0;
        reset = 1'b1;
        #1;
        chk_cnt++;
        if ({gnt0, gnt1} !== 2'b10) $display("FAIL reset_release_gnt: got %b, expected 10", {gnt0, gnt1});
        else pass_cnt++;
        req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        req0 = 1'b1; addr0 = 3'd5; data0 = 8'hAB;
        #1;
        chk_cnt++;
        if ({gnt0, gnt1} !== 2'b10) $display("FAIL single0_gnt: got %b, expected 10", {gnt0, gnt1});
        else pass_cnt++;
        sb_q.push_back('{a: 3'd5, d: 8'hAB});
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({rf_load, mem[5]} !== {1'b0, 8'hAB}) $display("FAIL single0_land: got load=%b q5=%h, expected 0 ab", rf_load, mem[5]);
        else pass_cnt++;
        req1 = 1'b1; addr1 = 3'd6; data1 = 8'hCD;
        #1;
        chk_cnt++;
        if ({gnt0, gnt1} !== 2'b01) $display("FAIL single1_gnt: got %b, expected 01", {gnt0, gnt1});
        else pass_cnt++;
        sb_q.push_back('{a: 3'd6, d: 8'hCD});
        @(negedge clk);
        req1 = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({rf_load, mem[6]} !== {1'b0, 8'hCD}) $display("FAIL single1_land: got load=%b q6=%h, expected 0 cd", rf_load, mem[6]);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        req0 = 1'b1; addr0 = 3'd1; data0 = 8'h11;
        req1 = 1'b1; addr1 = 3'd2; data1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_cnt++;
            if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
                $display("FAIL contention_gnt%0d: got %b, expected %b", i, {gnt0, gnt1}, ((i % 2 == 0) ? 2'b10 : 2'b01));
            else pass_cnt++;
            if (i % 2 == 0) sb_q.push_back('{a: 3'd1, d: 8'h11});
            else sb_q.push_back('{a: 3'd2, d: 8'h22});
            @(negedge clk);
            chk_cnt++;
            if (rf_load !== 1'b1) $display("FAIL contention_load%0d: got %b, expected 1", i, rf_load);
            else pass_cnt++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (rf_load !== 1'b0) $display("FAIL contention_idle: got %b, expected 0", rf_load);
        else pass_cnt++;
    endtask

    task automatic load_all();
        for (int i = 0; i < 8; i++) begin
            req0 = 1'b1; addr0 = 3'(i); data0 = 8'hAA + 8'(i);
            #1;
            chk_cnt++;
            if (gnt0 !== 1'b1) $display("FAIL load_gnt%0d: got %b, expected 1", i, gnt0);
            else pass_cnt++;
            sb_q.push_back('{a: 3'(i), d: 8'hAA + 8'(i)});
            @(negedge clk);
        end
        req0 = 1'b0;
    endtask

    task automatic test_sweep();
        load_all();
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_cnt++;
            if ({busy, rf_reset, rf_load, clear_done, rf_address} !== {4'b1100, 3'(k)})
                $display("FAIL sweep_step%0d: got %b, expected %b", k,
                         {busy, rf_reset, rf_load, clear_done, rf_address}, {4'b1100, 3'(k)});
            else pass_cnt++;
            chk_cnt++;
            if ({gnt0, gnt1} !== 2'b00) $display("FAIL sweep_gnt%0d: got %b, expected 00", k, {gnt0, gnt1});
            else pass_cnt++;
            @(negedge clk);
        end
        chk_cnt++;
        if ({busy, rf_reset, clear_done} !== 3'b001) $display("FAIL sweep_end: got %b, expected 001", {busy, rf_reset, clear_done});
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (clear_done !== 1'b0) $display("FAIL sweep_done_pulse: got %b, expected 0", clear_done);
        else pass_cnt++;
        for (int r = 0; r < 8; r++) begin
            chk_cnt++;
            if (mem[r] !== 8'h00) $display("FAIL sweep_reg%0d: got %h, expected 00", r, mem[r]);
            else pass_cnt++;
        end
    endtask

    task automatic test_clear_vs_write();
        clear_all = 1'b1; req1 = 1'b1; addr1 = 3'd4; data1 = 8'h5C;
        #1;
        chk_cnt++;
        if ({gnt0, gnt1} !== 2'b00) $display("FAIL cvw_gnt: got %b, expected 00", {gnt0, gnt1});
        else pass_cnt++;
        @(negedge clk);
        clear_all = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk_cnt++;
            if ({busy, gnt1} !== 2'b10) $display("FAIL cvw_hold%0d: got busy/gnt1=%b, expected 10", k, {busy, gnt1});
            else pass_cnt++;
            @(negedge clk);
        end
        #1;
        chk_cnt++;
        if ({busy, gnt1} !== 2'b01) $display("FAIL cvw_after: got busy/gnt1=%b, expected 01", {busy, gnt1});
        else pass_cnt++;
        sb_q.push_back('{a: 3'd4, d: 8'h5C});
        @(negedge clk);
        req1 = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (mem[4] !== 8'h5C) $display("FAIL cvw_data: got %h, expected 5c", mem[4]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_sweep();
        load_all();
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({rf_reset, rf_address} !== {1'b1, 3'd3}) $display("FAIL mid_addr: got %b, expected 1011", {rf_reset, rf_address});
        else pass_cnt++;
        reset = 1'b0;
        #1;
        chk_cnt++;
        if ({rf_load, rf_reset, rf_address, rf_d_in, clear_done, busy, gnt0, gnt1} !== 17'd0)
            $display("FAIL mid_reset_outputs: got %h, expected 0",
                     {rf_load, rf_reset, rf_address, rf_d_in, clear_done, busy, gnt0, gnt1});
        else pass_cnt++;
        for (int r = 0; r < 8; r++) begin
            chk_cnt++;
            if (mem[r] !== ((r < 3) ? 8'h00 : 8'hAA + 8'(r)))
                $display("FAIL mid_reg%0d: got %h, expected %h", r, mem[r], ((r < 3) ? 8'h00 : 8'hAA + 8'(r)));
            else pass_cnt++;
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({busy, clear_done, rf_reset} !== 3'b000) $display("FAIL mid_no_resume: got %b, expected 000", {busy, clear_done, rf_reset});
        else pass_cnt++;
    endtask

    // Test sequence
    initial begin
        reset = 1'b0;
        req0 = 1'b1; addr0 = 3'd0; data0 = 8'h00;
        req1 = 1'b0; addr1 = 3'd0; data1 = 8'h00;
        clear_all = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_sweep();
        test_clear_vs_write();
        test_reset_mid_sweep();
        chk_cnt++;
        if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending, expected 0", sb_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
